// File: rtl/timestamp_arbiter_pkg.sv
// Shared word-layout constants for the timestamp arbiter output stream.
package timestamp_arbiter_pkg;

   localparam int WORD_W   = 64;
   localparam int TYPE_BIT = 63;  // 0 = event word, 1 = tag word
   localparam int CH_LSB   = 60;  // channel index field position
   localparam int CH_W     = 3;   // channel index field width
   localparam int TAG_W    = 48;  // coarse period field width
   localparam int N_CH_MAX = 8;

   localparam logic TYPE_EVENT = 1'b0;
   localparam logic TYPE_TAG   = 1'b1;

   // Build a tag word around a captured coarse period value.
   function automatic logic [WORD_W-1:0] tag_word(input logic [TAG_W-1:0] period);
      tag_word = {TYPE_TAG, {(WORD_W-1-TAG_W){1'b0}}, period};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer moves
// past the granted requester only when the grant is actually taken.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_i,
   input  logic                 accept_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] gnt_idx_o,
   output logic                 any_o
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr_q, ptr_d;

   // Search from ptr_q upward with wrap; scanning backwards lets the
   // requester closest to the pointer overwrite farther ones.
   always_comb begin
      int idx;
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      idx       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (req_i[idx]) begin
            gnt_o          = '0;
            gnt_o[idx]     = 1'b1;
            gnt_idx_o      = idx[IW-1:0];
            any_o          = 1'b1;
         end
      end
   end

   // Next pointer: the channel after the one just granted.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_i && any_o) begin
         if (int'(gnt_idx_o) == N - 1) ptr_d = '0;
         else                          ptr_d = gnt_idx_o + 1'b1;
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/timestamp_arbiter.sv
// Merges per-channel timestamped hits and coarse period tags into a single
// 64-bit output stream with a one-word output register.
module timestamp_arbiter
   import timestamp_arbiter_pkg::*;
#(
   parameter int COUNTER = 19,
   parameter int N_CH    = 4,
   parameter int DATA_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [COUNTER-1:0]       counter,
   input  logic [TAG_W-1:0]         period,
   input  logic                     period_done,
   input  logic [N_CH-1:0]          ch_valid,
   input  logic [N_CH*DATA_W-1:0]   ch_data,
   output logic [N_CH-1:0]          ch_ready,
   output logic                     out_valid,
   output logic [WORD_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic                     tag_overrun
);

   localparam int IW = $clog2(N_CH);

   // Per-channel hold registers
   logic [N_CH-1:0]              hold_full_q, hold_full_d;
   logic [N_CH-1:0][DATA_W-1:0]  hold_data_q;
   logic [N_CH-1:0][COUNTER-1:0] hold_cnt_q;

   // Tag path: pd_q marks "capture period this cycle"
   logic             pd_q, pd_d;
   logic             tag_pend_q, tag_pend_d;
   logic             tag_cap_q, tag_cap_d;
   logic [TAG_W-1:0] tag_val_q, tag_val_d;
   logic             tag_ovr_q, tag_ovr_d;

   // Output register
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_data_q, out_data_d;

   logic [N_CH-1:0] hit, rr_gnt, ch_gnt;
   logic [IW-1:0]   rr_idx;
   logic            rr_any, load, tag_avail, tag_gnt, rr_adv, pd_new;
   logic [WORD_W-1:0] evt_word;

   // Ready is withheld during reset so no hit is counted as accepted there.
   assign ch_ready  = (en && !rst) ? ~hold_full_q : '0;
   assign hit       = ch_valid & ch_ready;
   assign load      = !out_valid_q || out_ready;
   assign tag_avail = tag_pend_q && tag_cap_q;
   assign tag_gnt   = load && tag_avail;
   assign rr_adv    = load && !tag_avail;
   assign ch_gnt    = rr_adv ? rr_gnt : '0;
   assign pd_new    = period_done && en;

   rr_arbiter #(.N(N_CH)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .req_i     (hold_full_q),
      .accept_i  (rr_adv),
      .gnt_o     (rr_gnt),
      .gnt_idx_o (rr_idx),
      .any_o     (rr_any)
   );

   // Event word for the currently selected hold.
   always_comb begin
      evt_word                       = '0;
      evt_word[TYPE_BIT]             = TYPE_EVENT;
      evt_word[CH_LSB +: IW]         = rr_idx;
      evt_word[COUNTER +: DATA_W]    = hold_data_q[rr_idx];
      evt_word[COUNTER-1:0]          = hold_cnt_q[rr_idx];
   end

   // Next state for holds, tag tracking and the output register.
   always_comb begin
      hold_full_d = (hold_full_q & ~ch_gnt) | hit;

      pd_d       = pd_new;
      tag_pend_d = tag_pend_q;
      tag_cap_d  = tag_cap_q;
      tag_val_d  = tag_val_q;
      tag_ovr_d  = tag_ovr_q;
      if (tag_gnt) begin
         tag_pend_d = 1'b0;
         tag_cap_d  = 1'b0;
      end
      if (pd_q) begin
         tag_val_d = period;
         tag_cap_d = 1'b1;
      end
      // A new rollover replaces any unsent tag; its value arrives next cycle.
      if (pd_new) begin
         if (tag_pend_q && !tag_gnt) tag_ovr_d = 1'b1;
         tag_pend_d = 1'b1;
         tag_cap_d  = 1'b0;
      end

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (load) begin
         if (tag_avail) begin
            out_valid_d = 1'b1;
            out_data_d  = tag_word(tag_val_q);
         end else if (rr_any) begin
            out_valid_d = 1'b1;
            out_data_d  = evt_word;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full_q <= '0;
         pd_q        <= 1'b0;
         tag_pend_q  <= 1'b0;
         tag_cap_q   <= 1'b0;
         tag_val_q   <= '0;
         tag_ovr_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         hold_full_q <= hold_full_d;
         pd_q        <= pd_d;
         tag_pend_q  <= tag_pend_d;
         tag_cap_q   <= tag_cap_d;
         tag_val_q   <= tag_val_d;
         tag_ovr_q   <= tag_ovr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Hold payload/timestamp capture; qualified by the full flag, no reset needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (hit[i]) begin
            hold_data_q[i] <= ch_data[i*DATA_W +: DATA_W];
            hold_cnt_q[i]  <= counter;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign tag_overrun = tag_ovr_q;

endmodule

// File: tb/tb_timestamp_arbiter.sv
// Directed bench for timestamp_arbiter with a queue-based output scoreboard.
module tb_timestamp_arbiter;

   localparam int N  = 4;
   localparam int CW = 19;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst, en, period_done, out_ready;
   logic [CW-1:0]   counter;
   logic [47:0]     period;
   logic [N-1:0]    ch_valid, ch_ready;
   logic [N*DW-1:0] ch_data;
   logic            out_valid, tag_overrun;
   logic [63:0]     out_data;

   logic [63:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   timestamp_arbiter #(.COUNTER(CW), .N_CH(N), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .counter     (counter),
      .period      (period),
      .period_done (period_done),
      .ch_valid    (ch_valid),
      .ch_data     (ch_data),
      .ch_ready    (ch_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .tag_overrun (tag_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ev(input int ch, input logic [DW-1:0] d, input logic [CW-1:0] c);
      logic [63:0] w;
      w = '0;
      w[62:60] = 3'(ch);
      w[CW +: DW] = d;
      w[CW-1:0] = c;
      return w;
   endfunction

   function automatic logic [63:0] tg(input logic [47:0] p);
      return {1'b1, 15'd0, p};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every transfer must match the oldest expected word.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", out_data);
         end else begin
            check("out_word", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [DW-1:0] d);
      ch_data[ch*DW +: DW] = d;
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ch_valid = '0;
      period_done = 1'b0;
      step();
      step();
      exp_q.delete();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; period_done = 1'b0; out_ready = 1'b1;
      counter = '0; period = '0; ch_valid = '0; ch_data = '0;
      step();
      step();
      // Reset state
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_overrun", 64'(tag_overrun), 64'd0);
      check("rst_ch_ready", 64'(ch_ready), 64'd0);
      rst = 1'b0;
      step();
      check("rel_ch_ready", 64'(ch_ready), 64'hF);

      // Single hit on ch2, latency and layout
      counter = 19'h1234;
      set_data(2, 16'hBEEF);
      ch_valid = 4'b0100;
      exp_q.push_back(64'h2000_0005_F778_1234);
      step();
      ch_valid = '0;
      check("lat_k", 64'(out_valid), 64'd0);
      step();
      check("lat_k1", 64'(out_valid), 64'd1);
      check("single_word", out_data, 64'h2000_0005_F778_1234);
      drain(10);

      // All channels continuously valid: fair rotation 0,1,2,3,0,1
      do_reset();
      counter = 19'hAA;
      for (int i = 0; i < N; i++) set_data(i, 16'(16'hA000 + i));
      exp_q.push_back(ev(0, 16'hA000, 19'hAA));
      exp_q.push_back(ev(1, 16'hA001, 19'hAA));
      exp_q.push_back(ev(2, 16'hA002, 19'hAA));
      exp_q.push_back(ev(3, 16'hA003, 19'hAA));
      exp_q.push_back(ev(0, 16'hA000, 19'hAA));
      exp_q.push_back(ev(1, 16'hA001, 19'hAA));
      ch_valid = 4'hF;
      repeat (4) step();
      ch_valid = '0;
      drain(20);

      // Tag preempts pending holds; period sampled one cycle after the pulse
      do_reset();
      out_ready = 1'b0;
      counter = 19'h77;
      for (int i = 0; i < N; i++) set_data(i, 16'(16'h4400 + i));
      exp_q.push_back(ev(0, 16'h4400, 19'h77));
      exp_q.push_back(tg(48'd5));
      exp_q.push_back(ev(1, 16'h4401, 19'h77));
      exp_q.push_back(ev(2, 16'h4402, 19'h77));
      period = 48'd9;
      ch_valid = 4'b0111;
      step();
      ch_valid = '0;
      step();
      period_done = 1'b1;
      step();
      period_done = 1'b0;
      period = 48'd5;
      step();
      period = 48'd9;
      out_ready = 1'b1;
      drain(20);
      check("tag_no_overrun", 64'(tag_overrun), 64'd0);

      // Back-pressure for 10 cycles with all channels hitting
      do_reset();
      out_ready = 1'b0;
      counter = 19'h3C;
      for (int i = 0; i < N; i++) set_data(i, 16'(16'h5500 + i));
      exp_q.push_back(ev(0, 16'h5500, 19'h3C));
      exp_q.push_back(ev(1, 16'h5501, 19'h3C));
      exp_q.push_back(ev(2, 16'h5502, 19'h3C));
      exp_q.push_back(ev(3, 16'h5503, 19'h3C));
      exp_q.push_back(ev(0, 16'h5500, 19'h3C));
      ch_valid = 4'hF;
      repeat (3) step();
      for (int c = 0; c < 8; c++) begin
         check("bp_ch_ready", 64'(ch_ready), 64'd0);
         check("bp_out_data", out_data, ev(0, 16'h5500, 19'h3C));
         step();
      end
      ch_valid = '0;
      out_ready = 1'b1;
      drain(20);

      // Two rollovers while stalled: overrun, only newer tag emitted
      do_reset();
      check("ovr_after_rst", 64'(tag_overrun), 64'd0);
      out_ready = 1'b0;
      counter = 19'h10;
      set_data(0, 16'h6600);
      exp_q.push_back(ev(0, 16'h6600, 19'h10));
      exp_q.push_back(tg(48'h222));
      ch_valid = 4'b0001;
      step();
      ch_valid = '0;
      step();
      period_done = 1'b1;
      step();
      period_done = 1'b0;
      period = 48'h111;
      step();
      period = '0;
      check("ovr_first", 64'(tag_overrun), 64'd0);
      step();
      period_done = 1'b1;
      step();
      period_done = 1'b0;
      period = 48'h222;
      step();
      period = '0;
      check("ovr_set", 64'(tag_overrun), 64'd1);
      out_ready = 1'b1;
      drain(20);

      // Reset mid-operation discards everything
      do_reset();
      check("ovr_cleared", 64'(tag_overrun), 64'd0);
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) set_data(i, 16'(16'h7700 + i));
      ch_valid = 4'hF;
      step();
      step();
      ch_valid = '0;
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      step();
      exp_q.delete();
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_data", out_data, 64'd0);
      rst = 1'b0;
      step();
      check("post_rst_ready", 64'(ch_ready), 64'hF);
      out_ready = 1'b1;
      repeat (6) step();
      check("post_rst_idle", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
